// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg -- shared definitions for the program-counter unit.
//
// Contents:
//   RESET_VEC_DEF / EXC_VEC_DEF  default reset and exception-entry addresses
//   next_sel_e                   which source the next PC comes from
//   sext_shift()                 branch offset: imm[15:0] << 2, as a signed
//                                18-bit value (callers widen it by
//                                replicating bit 17)
//
// Optional feature macro: PC_EXC_EN (exception entry / return). The EXC and
// ERET selects are only produced when it is defined.
// ---------------------------------------------------------------------------
package pc_pkg;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0180;

    typedef enum logic [2:0] {
        SEQ,   // pc + 4
        BR,    // taken conditional branch
        J,     // J / JAL
        JR,    // jump register
        EXC,   // exception entry
        ERET   // exception return
    } next_sel_e;

    // Word offset of a branch: the 16-bit immediate counts instructions, so
    // it is shifted left by two. The result stays signed; bit 17 is the sign.
    function automatic logic [17:0] sext_shift(input logic [15:0] imm16);
        return {imm16, 2'b00};
    endfunction

endpackage : pc_pkg

// File: rtl/pc_target.sv
// ---------------------------------------------------------------------------
// pc_target -- combinational next-PC computation and priority select.
//
// Ports:
//   pc_i        current PC
//   pc_wre_i    PC write enable; low means hold (controls ignored)
//   branch_i    conditional branch;  zero_i  ALU zero flag
//   jump_i      J/JAL;  jr_i  jump register
//   imm_i       instruction bits [25:0]
//   rs_val_i    jump-register target
//   exc_i, eret_i, epc_i   (PC_EXC_EN only) exception entry/return
//   pc_plus4_o  pc_i + 4 (wraps silently)
//   next_pc_o   selected target, meaningful when accept_o is high
//   sel_o       which source was selected
//   accept_o    the PC is updated this cycle
//   misalign_o  a jr was rejected because its target is not word-aligned
//
// Priority: exc (ignores pc_wre) > eret > jr > jump > taken branch > pc+4.
// Optional feature macro: PC_EXC_EN.
// ---------------------------------------------------------------------------
module pc_target
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
`ifdef PC_EXC_EN
    ,
    parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(EXC_VEC_DEF)
`endif
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_wre_i,
    input  logic              branch_i,
    input  logic              zero_i,
    input  logic              jump_i,
    input  logic              jr_i,
    input  logic [25:0]       imm_i,
    input  logic [ADDR_W-1:0] rs_val_i,
`ifdef PC_EXC_EN
    input  logic              exc_i,
    input  logic              eret_i,
    input  logic [ADDR_W-1:0] epc_i,
`endif
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic [ADDR_W-1:0] next_pc_o,
    output next_sel_e         sel_o,
    output logic              accept_o,
    output logic              misalign_o
);

    logic [17:0]       br_off_short;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;

    assign pc_plus4_o   = pc_i + ADDR_W'(4);
    assign br_off_short = sext_shift(imm_i[15:0]);
    assign br_off       = {{(ADDR_W-18){br_off_short[17]}}, br_off_short};
    assign br_target    = pc_plus4_o + br_off;

    // The jump target keeps the upper bits of pc+4 above bit 27; with a
    // 28-bit PC there are none.
    generate
        if (ADDR_W > 28) begin : g_j_region
            assign j_target = {pc_plus4_o[ADDR_W-1:28], imm_i, 2'b00};
        end else begin : g_j_flat
            assign j_target = {imm_i, 2'b00};
        end
    endgenerate

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // if/else chain can leave one unassigned and infer a latch.
        next_pc_o  = pc_i;
        sel_o      = SEQ;
        accept_o   = 1'b0;
        misalign_o = 1'b0;
`ifdef PC_EXC_EN
        if (exc_i) begin
            next_pc_o = EXC_VEC;
            sel_o     = EXC;
            accept_o  = 1'b1;
        end else if (pc_wre_i && eret_i) begin
            next_pc_o = epc_i;
            sel_o     = ERET;
            accept_o  = 1'b1;
        end else
`endif
        if (pc_wre_i) begin
            if (jr_i) begin
                sel_o = JR;
                if (rs_val_i[1:0] != 2'b00) begin
                    misalign_o = 1'b1;  // reject: PC holds, not counted
                end else begin
                    next_pc_o = rs_val_i;
                    accept_o  = 1'b1;
                end
            end else if (jump_i) begin
                next_pc_o = j_target;
                sel_o     = J;
                accept_o  = 1'b1;
            end else if (branch_i && zero_i) begin
                next_pc_o = br_target;
                sel_o     = BR;
                accept_o  = 1'b1;
            end else begin
                next_pc_o = pc_plus4_o;
                sel_o     = SEQ;
                accept_o  = 1'b1;
            end
        end
    end

endmodule : pc_target

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program counter with branch/jump/jr redirect, update counter
// and optional exception entry/return.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   pc_wre       PC write enable (low: hold, controls ignored)
//   branch, zero, jump, jr, imm[25:0], rs_val   next-PC controls
//   pc           current PC (registered)
//   pc_plus4     pc + 4 (combinational, JAL link address)
//   redirect     1 for one cycle after a non-sequential update
//   align_err    1 for one cycle after a rejected misaligned jr
//   upd_cnt      number of accepted PC updates (wraps)
//   exc, eret, epc   (PC_EXC_EN only) exception entry/return, saved PC
//
// Optional feature macro: PC_EXC_EN. All state lives here; target selection
// is in pc_target.
// ---------------------------------------------------------------------------
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF)
`ifdef PC_EXC_EN
    ,
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(EXC_VEC_DEF)
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_wre,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    input  logic              jr,
    input  logic [25:0]       imm,
    input  logic [ADDR_W-1:0] rs_val,
`ifdef PC_EXC_EN
    input  logic              exc,
    input  logic              eret,
    output logic [ADDR_W-1:0] epc,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              redirect,
    output logic              align_err,
    output logic [31:0]       upd_cnt
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       upd_cnt_q, upd_cnt_d;
    logic              redirect_q, redirect_d;
    logic              align_err_q, align_err_d;
`ifdef PC_EXC_EN
    logic [ADDR_W-1:0] epc_q, epc_d;
`endif

    logic [ADDR_W-1:0] next_pc;
    next_sel_e         sel;
    logic              accept;
    logic              misalign;

    pc_target #(
        .ADDR_W (ADDR_W)
`ifdef PC_EXC_EN
        ,
        .EXC_VEC(EXC_VEC)
`endif
    ) u_target (
        .pc_i      (pc_q),
        .pc_wre_i  (pc_wre),
        .branch_i  (branch),
        .zero_i    (zero),
        .jump_i    (jump),
        .jr_i      (jr),
        .imm_i     (imm),
        .rs_val_i  (rs_val),
`ifdef PC_EXC_EN
        .exc_i     (exc),
        .eret_i    (eret),
        .epc_i     (epc_q),
`endif
        .pc_plus4_o(pc_plus4),
        .next_pc_o (next_pc),
        .sel_o     (sel),
        .accept_o  (accept),
        .misalign_o(misalign)
    );

    always_comb begin
        pc_d        = pc_q;
        upd_cnt_d   = upd_cnt_q;
        redirect_d  = accept && (sel != SEQ);
        align_err_d = misalign;
`ifdef PC_EXC_EN
        epc_d       = epc_q;
`endif
        if (accept) begin
            pc_d      = next_pc;
            upd_cnt_d = upd_cnt_q + 32'd1;
`ifdef PC_EXC_EN
            if (sel == EXC) begin
                epc_d = pc_q;
            end
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_VEC;
            upd_cnt_q   <= '0;
            redirect_q  <= 1'b0;
            align_err_q <= 1'b0;
`ifdef PC_EXC_EN
            epc_q       <= '0;
`endif
        end else begin
            pc_q        <= pc_d;
            upd_cnt_q   <= upd_cnt_d;
            redirect_q  <= redirect_d;
            align_err_q <= align_err_d;
`ifdef PC_EXC_EN
            epc_q       <= epc_d;
`endif
        end
    end

    assign pc        = pc_q;
    assign upd_cnt   = upd_cnt_q;
    assign redirect  = redirect_q;
    assign align_err = align_err_q;
`ifdef PC_EXC_EN
    assign epc       = epc_q;
`endif

endmodule : pc_unit

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter: ADDR_W, 32, PC width in bits; legal range 28..64.
REQ-002 Parameter: RESET_VEC, 0, PC value loaded by reset; word-aligned.
REQ-003 Parameter: EXC_VEC, 32'h0000_0180, exception entry address; word-aligned; used only with PC_EXC_EN.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 pc_wre  in  1  PC write enable; low means hold.
REQ-008 branch  in  1  conditional-branch instruction.
REQ-009 zero  in  1  ALU zero flag.
REQ-010 jump  in  1  J/JAL instruction.
REQ-011 jr  in  1  jump-register instruction.
REQ-012 imm  in  26  instruction bits [25:0].
REQ-013 rs_val  in  ADDR_W  register target for jr.
REQ-014 pc  out  ADDR_W  current PC, registered.
REQ-015 pc_plus4  out  ADDR_W  pc+4, combinational; link address for JAL.
REQ-016 redirect  out  1  registered; 1 for one cycle after a non-sequential PC update.
REQ-017 align_err  out  1  registered; 1 for one cycle after a rejected misaligned jr.
REQ-018 upd_cnt  out  32  count of accepted PC updates.
REQ-019 exc, eret  in  1 each; epc  out  ADDR_W. These exist only with PC_EXC_EN.

Function
REQ-020 pc_plus4 = pc + 4, modulo 2^ADDR_W; 0xFFFF_FFFC wraps to 0 with no flag.
REQ-021 Branch target: pc_plus4 + (sign-extended imm[15:0] << 2), modulo 2^ADDR_W.
REQ-022 Jump target: {pc_plus4[ADDR_W-1:28], imm, 2'b00}.
REQ-023 When pc_wre=1, next-PC priority: jr > jump > (branch && zero) > pc_plus4.
REQ-024 Branch with zero=0 takes pc_plus4.
REQ-025 jr with rs_val[1:0]!=0: pc holds; align_err=1 next cycle; upd_cnt unchanged; redirect=0.
REQ-026 Any accepted jr, jump, or taken branch: redirect=1 next cycle; otherwise redirect=0.
REQ-027 upd_cnt increments by 1 on each accepted PC update (pc_wre=1, not rejected); wraps at 2^32-1 to 0.
REQ-028 pc_wre=0: pc, upd_cnt hold; redirect=0, align_err=0; all control inputs ignored.
REQ-029 Latency: pc reflects the selected target the cycle after the rising edge at which it is sampled; no internal pipelining.

Reset
REQ-030 rst=1 at a rising edge: pc=RESET_VEC, upd_cnt=0, redirect=0, align_err=0, epc=0.
REQ-031 rst has priority over every input, including exc and pc_wre, at any point mid-operation.

Configuration
REQ-032 Macro PC_EXC_EN: when defined, it adds exc, eret, and epc.
REQ-033 exc=1, independent of pc_wre: epc<=pc, pc<=EXC_VEC, redirect=1, upd_cnt+1; exc overrides all other controls.
REQ-034 eret=1 with pc_wre=1 (exc=0): pc<=epc, redirect=1; priority above jr.
REQ-035 exc and eret asserted in the same cycle: exc wins.
REQ-036 PC_EXC_EN undefined: those ports and EXC_VEC logic are absent; behaviour is REQ-020..031 only.

Structure
REQ-037 Package pc_pkg holds RESET_VEC and EXC_VEC defaults, the next-PC select enum (SEQ, BR, J, JR, EXC, ERET), and the sign-extend/shift function.
REQ-038 One sub-module, pc_target: combinational target computation and priority select; pc_unit keeps all registers.

Verification
REQ-039 Reset, then 3 cycles with pc_wre=1 and no controls -> pc=0,4,8,12; upd_cnt=3.
REQ-040 pc=0x100, branch=1, zero=1, imm[15:0]=0xFFFE -> pc=0x0FC, redirect=1; same with zero=0 -> pc=0x104.
REQ-041 pc=0x1000_0000, jump=1, branch=1, zero=1, imm=0x0000040 -> pc=0x1000_0100 (jump wins).
REQ-042 jr=1, rs_val=0x2002 -> pc holds, align_err=1 for one cycle; rs_val=0x2000 -> pc=0x2000.
REQ-043 pc=0xFFFF_FFFC, pc_wre=1 -> pc=0; pc_wre=0 with jump=1 -> pc holds, upd_cnt holds.
REQ-044 PC_EXC_EN: pc=0x400, exc=1 with pc_wre=0 -> pc=0x180, epc=0x400; then eret=1, pc_wre=1 -> pc=0x400; rst mid-sequence -> pc=RESET_VEC, epc=0.
